// File: rtl/simd_vec_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simd_vec_sequencer_pkg
// Description : Shared definitions for the SIMD vector sequencer.
//               - 3-bit ALU command encodings, matching the SIMD ALU core.
//               - Sequencer FSM state encodings.
//               - Per-vector cycle cost and index-width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package simd_vec_sequencer_pkg;

    // Width of one ALU lane / one memory word
    localparam int LANE_W = 32;

    // ALU command encodings understood by the core
    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_AND = 3'd2;
    localparam logic [2:0] CMD_OR  = 3'd3;
    localparam logic [2:0] CMD_XOR = 3'd4;
    localparam logic [2:0] CMD_SLT = 3'd5;
    localparam logic [2:0] CMD_SLL = 3'd6;
    localparam logic [2:0] CMD_SRL = 3'd7;

    // Sequencer states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_STORE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Cycles spent per vector: 2*lanes loads, drain, exec, lanes stores
    function automatic int unsigned vec_cycles(input int unsigned lanes);
        return 3 * lanes + 2;
    endfunction

    // Index width able to address n entries, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simd_lane_buffer.sv
`default_nettype none
// ============================================================================
// Module      : simd_lane_buffer
// Description : ALUWIDTH x 32-bit lane register file. One lane can be written
//               by index, or all lanes loaded at once from a flat vector.
//               All lanes are always visible on a flat read bus.
// Ports       : clk, reset (async, active-high)
//               wr_en_i / wr_idx_i / wr_data_i : single-lane write
//               load_all_i / load_data_i       : whole-vector load (priority)
//               rd_flat_o                      : lane i at [32*i +: 32]
// Revision    : 1.0 - initial release
// ============================================================================
module simd_lane_buffer
    import simd_vec_sequencer_pkg::*;
#(
    parameter int ALUWIDTH = 4,
    parameter int IDXW     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en_i,
    input  logic [IDXW-1:0]            wr_idx_i,
    input  logic [LANE_W-1:0]          wr_data_i,
    input  logic                       load_all_i,
    input  logic [LANE_W*ALUWIDTH-1:0] load_data_i,
    output logic [LANE_W*ALUWIDTH-1:0] rd_flat_o
);

    logic [LANE_W-1:0] lane_q [ALUWIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ALUWIDTH; i++) begin
                lane_q[i] <= '0;
            end
        end else if (load_all_i) begin
            for (int i = 0; i < ALUWIDTH; i++) begin
                lane_q[i] <= load_data_i[LANE_W*i +: LANE_W];
            end
        end else if (wr_en_i) begin
            lane_q[wr_idx_i] <= wr_data_i;
        end
    end

    generate
        for (genvar g = 0; g < ALUWIDTH; g++) begin : g_rd_lane
            assign rd_flat_o[LANE_W*g +: LANE_W] = lane_q[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/simd_vec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : simd_vec_sequencer
// Description : Runs the SIMD ALU core over req_count vectors in memory.
//               Per vector: read ALUWIDTH A lanes then ALUWIDTH B lanes,
//               drain the last read, execute once, write ALUWIDTH results.
// Ports       : req_*      - valid/ready request from issue logic
//               done       - one-cycle completion pulse
//               ovf_sticky - OR of all lane overflows of the request
//               zero_mask  - iszero flags of the last executed vector
//               mem_*      - single-port memory, read data one cycle late
//               core_*     - SIMD ALU core (combinational)
// Option      : SIMD_SEQ_PERF_EN adds perf_cycles / perf_vectors counters.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_vec_sequencer
    import simd_vec_sequencer_pkg::*;
#(
    parameter int ALUWIDTH = 4,
    parameter int ADDRW    = 32,
    parameter int CNTW     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [2:0]                 req_cmd,
    input  logic [ADDRW-1:0]           req_a_base,
    input  logic [ADDRW-1:0]           req_b_base,
    input  logic [ADDRW-1:0]           req_d_base,
    input  logic [CNTW-1:0]            req_count,
    output logic                       done,
    output logic                       ovf_sticky,
    output logic [ALUWIDTH-1:0]        zero_mask,
`ifdef SIMD_SEQ_PERF_EN
    output logic [31:0]                perf_cycles,
    output logic [31:0]                perf_vectors,
`endif
    output logic [ADDRW-1:0]           mem_addr,
    output logic                       mem_rd_en,
    input  logic [LANE_W-1:0]          mem_rdata,
    output logic                       mem_wr_en,
    output logic [LANE_W-1:0]          mem_wdata,
    output logic [2:0]                 core_command,
    output logic [LANE_W*ALUWIDTH-1:0] core_opA_s,
    output logic [LANE_W*ALUWIDTH-1:0] core_opB_s,
    input  logic [LANE_W*ALUWIDTH-1:0] core_result_s,
    input  logic [ALUWIDTH-1:0]        core_iszero_s,
    input  logic [ALUWIDTH-1:0]        core_overflow_s
);

    localparam int IDXW = idx_w(ALUWIDTH);
    localparam int KW   = idx_w(2 * ALUWIDTH);
    localparam logic [KW-1:0] K_LANES      = KW'(ALUWIDTH);
    localparam logic [KW-1:0] K_LOAD_LAST  = KW'(2 * ALUWIDTH - 1);
    localparam logic [KW-1:0] K_STORE_LAST = KW'(ALUWIDTH - 1);

    logic [2:0]          state_q, state_d;
    logic [KW-1:0]       k_q, k_d;          // step within LOAD / STORE
    logic [CNTW-1:0]     v_q, v_d;          // vector index
    logic [2:0]          cmd_q, cmd_d;
    logic [ADDRW-1:0]    a_base_q, a_base_d;
    logic [ADDRW-1:0]    b_base_q, b_base_d;
    logic [ADDRW-1:0]    d_base_q, d_base_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [ALUWIDTH-1:0] zmask_q, zmask_d;
    logic [ADDRW-1:0]    addr_q;            // last strobed address, held when idle
    logic [LANE_W-1:0]   wdata_q;           // last written word, held when idle
    logic                cap_valid_q;       // a read was issued last cycle
    logic [KW-1:0]       cap_k_q;           // load step of that read

    logic [KW-1:0]             w_lane_k;
    logic [ADDRW-1:0]          w_voff;
    logic [ADDRW-1:0]          w_base;
    logic [ADDRW-1:0]          w_addr;
    logic [LANE_W-1:0]         w_store_word;
    logic [LANE_W*ALUWIDTH-1:0] w_res_flat;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        v_d      = v_q;
        cmd_d    = cmd_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        d_base_d = d_base_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        zmask_d  = zmask_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cmd_d    = req_cmd;
                    a_base_d = req_a_base;
                    b_base_d = req_b_base;
                    d_base_d = req_d_base;
                    count_d  = req_count;
                    ovf_d    = 1'b0;
                    v_d      = '0;
                    k_d      = '0;
                    state_d  = (req_count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (k_q == K_LOAD_LAST) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                ovf_d   = ovf_q | (|core_overflow_s);
                zmask_d = core_iszero_s;
                k_d     = '0;
                state_d = ST_STORE;
            end
            ST_STORE: begin
                if (k_q == K_STORE_LAST) begin
                    k_d     = '0;
                    v_d     = v_q + CNTW'(1);
                    state_d = (v_d == count_q) ? ST_DONE : ST_LOAD;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory address / data path
    // ------------------------------------------------------------------
    assign w_lane_k = (k_q >= K_LANES) ? (k_q - K_LANES) : k_q;
    assign w_voff   = ADDRW'(v_q) * ADDRW'(ALUWIDTH);
    assign w_base   = (state_q == ST_LOAD) ? ((k_q >= K_LANES) ? b_base_q : a_base_q)
                                           : d_base_q;
    assign w_addr   = w_base + w_voff + ADDRW'(w_lane_k);

    always_comb begin
        w_store_word = '0;
        for (int i = 0; i < ALUWIDTH; i++) begin
            if (k_q == KW'(i)) begin
                w_store_word = w_res_flat[LANE_W*i +: LANE_W];
            end
        end
    end

    assign mem_rd_en = (state_q == ST_LOAD);
    assign mem_wr_en = (state_q == ST_STORE);
    assign mem_addr  = (mem_rd_en || mem_wr_en) ? w_addr : addr_q;
    assign mem_wdata = mem_wr_en ? w_store_word : wdata_q;

    assign req_ready    = (state_q == ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign ovf_sticky   = ovf_q;
    assign zero_mask    = zmask_q;
    assign core_command = cmd_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            v_q         <= '0;
            cmd_q       <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            d_base_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            zmask_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cap_valid_q <= 1'b0;
            cap_k_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            v_q         <= v_d;
            cmd_q       <= cmd_d;
            a_base_q    <= a_base_d;
            b_base_q    <= b_base_d;
            d_base_q    <= d_base_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            zmask_q     <= zmask_d;
            addr_q      <= mem_addr;
            wdata_q     <= mem_wdata;
            cap_valid_q <= mem_rd_en;
            cap_k_q     <= k_q;
        end
    end

    // ------------------------------------------------------------------
    // Lane buffers: read data lands one cycle after its strobe, so the
    // capture is steered by the step recorded alongside that strobe.
    // ------------------------------------------------------------------
    simd_lane_buffer #(.ALUWIDTH(ALUWIDTH), .IDXW(IDXW)) u_buf_a (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (cap_valid_q && (cap_k_q < K_LANES)),
        .wr_idx_i    (IDXW'(cap_k_q)),
        .wr_data_i   (mem_rdata),
        .load_all_i  (1'b0),
        .load_data_i ('0),
        .rd_flat_o   (core_opA_s)
    );

    simd_lane_buffer #(.ALUWIDTH(ALUWIDTH), .IDXW(IDXW)) u_buf_b (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (cap_valid_q && (cap_k_q >= K_LANES)),
        .wr_idx_i    (IDXW'(cap_k_q - K_LANES)),
        .wr_data_i   (mem_rdata),
        .load_all_i  (1'b0),
        .load_data_i ('0),
        .rd_flat_o   (core_opB_s)
    );

    simd_lane_buffer #(.ALUWIDTH(ALUWIDTH), .IDXW(IDXW)) u_buf_r (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (1'b0),
        .wr_idx_i    ('0),
        .wr_data_i   ('0),
        .load_all_i  (state_q == ST_EXEC),
        .load_data_i (core_result_s),
        .rd_flat_o   (w_res_flat)
    );

`ifdef SIMD_SEQ_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_vectors_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles_q  <= '0;
            perf_vectors_q <= '0;
        end else begin
            if (state_q != ST_IDLE) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if ((state_q == ST_STORE) && (k_q == K_STORE_LAST)) begin
                perf_vectors_q <= perf_vectors_q + 32'd1;
            end
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_vectors = perf_vectors_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simd_vec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_vec_sequencer
// Description : Directed self-checking bench for simd_vec_sequencer with a
//               behavioural ALU core and a 256-word memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_vec_sequencer;
    import simd_vec_sequencer_pkg::*;

    localparam int W  = 4;
    localparam int AW = 32;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_cmd;
    logic [AW-1:0]   req_a_base, req_b_base, req_d_base;
    logic [CW-1:0]   req_count;
    logic            done, ovf_sticky;
    logic [W-1:0]    zero_mask;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd_en, mem_wr_en;
    logic [31:0]     mem_rdata = '0;
    logic [31:0]     mem_wdata;
    logic [2:0]      core_command;
    logic [32*W-1:0] core_opA_s, core_opB_s, core_result_s;
    logic [W-1:0]    core_iszero_s, core_overflow_s;
`ifdef SIMD_SEQ_PERF_EN
    logic [31:0]     perf_cycles, perf_vectors;
`endif

    always #5 clk = ~clk;

    simd_vec_sequencer #(.ALUWIDTH(W), .ADDRW(AW), .CNTW(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_cmd         (req_cmd),
        .req_a_base      (req_a_base),
        .req_b_base      (req_b_base),
        .req_d_base      (req_d_base),
        .req_count       (req_count),
        .done            (done),
        .ovf_sticky      (ovf_sticky),
        .zero_mask       (zero_mask),
`ifdef SIMD_SEQ_PERF_EN
        .perf_cycles     (perf_cycles),
        .perf_vectors    (perf_vectors),
`endif
        .mem_addr        (mem_addr),
        .mem_rd_en       (mem_rd_en),
        .mem_rdata       (mem_rdata),
        .mem_wr_en       (mem_wr_en),
        .mem_wdata       (mem_wdata),
        .core_command    (core_command),
        .core_opA_s      (core_opA_s),
        .core_opB_s      (core_opB_s),
        .core_result_s   (core_result_s),
        .core_iszero_s   (core_iszero_s),
        .core_overflow_s (core_overflow_s)
    );

    // Behavioural ALU core (ADD / SUB, anything else XOR)
    logic [31:0] m_a, m_b, m_r;
    always_comb begin
        core_result_s   = '0;
        core_iszero_s   = '0;
        core_overflow_s = '0;
        m_a = '0;
        m_b = '0;
        m_r = '0;
        for (int i = 0; i < W; i++) begin
            m_a = core_opA_s[32*i +: 32];
            m_b = core_opB_s[32*i +: 32];
            case (core_command)
                CMD_ADD: begin
                    m_r = m_a + m_b;
                    core_overflow_s[i] = (m_a[31] == m_b[31]) && (m_r[31] != m_a[31]);
                end
                CMD_SUB: begin
                    m_r = m_a - m_b;
                    core_overflow_s[i] = (m_a[31] != m_b[31]) && (m_r[31] != m_a[31]);
                end
                default: m_r = m_a ^ m_b;
            endcase
            core_result_s[32*i +: 32] = m_r;
            core_iszero_s[i] = (m_r == 32'd0);
        end
    end

    // Memory model with a bench preload port and strobe counters
    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;

    always @(posedge clk) begin
        if (pre_en)    mem[pre_addr] <= pre_data;
        if (mem_wr_en) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr[7:0]];
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
        if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    // Offer a request in IDLE; returns one step after the acceptance edge
    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic [7:0] n);
        @(negedge clk);
        req_cmd    = c;
        req_a_base = a;
        req_b_base = b;
        req_d_base = d;
        req_count  = n;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Cycles from acceptance to done; 2000 means it never came
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 2000) begin
            tick();
            lat++;
        end
    endtask

    int lat, rd0, wr0, n;

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_cmd    = '0;
        req_a_base = '0;
        req_b_base = '0;
        req_d_base = '0;
        req_count  = '0;
        #1;
        // ---- reset state ----
        chk("rst_ready", req_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_cmd", core_command, 0);
        chk("rst_ovf", ovf_sticky, 0);
        chk("rst_zmask", zero_mask, 0);
        chk("rst_opA", core_opA_s, 0);
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b0;

        // ---- single ADD vector ----
        for (int i = 0; i < 4; i++) begin
            preload(8'h10 + 8'(i), 32'(i + 1));
            preload(8'h20 + 8'(i), 32'(10 * (i + 1)));
        end
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        issue(CMD_ADD, 32'h10, 32'h20, 32'h30, 8'd1);
        chk("busy_ready_low", req_ready, 0);
        wait_done(lat);
        chk("t1_latency", lat, 15);
        chk("t1_ovf", ovf_sticky, 0);
        chk("t1_zmask", zero_mask, 4'b0000);
        chk("t1_mem0", mem[8'h30], 11);
        chk("t1_mem1", mem[8'h31], 22);
        chk("t1_mem2", mem[8'h32], 33);
        chk("t1_mem3", mem[8'h33], 44);
        chk("t1_addr_hold", mem_addr, 32'h33);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_ready_back", req_ready, 1);
        chk("t1_reads", rd_cnt - rd0, 8);
        chk("t1_writes", wr_cnt - wr0, 4);

        // ---- three consecutive vectors ----
        for (int i = 0; i < 12; i++) begin
            preload(8'h40 + 8'(i), 32'(i + 1));
            preload(8'h50 + 8'(i), 32'(1000 * (i + 1)));
        end
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        issue(CMD_ADD, 32'h40, 32'h50, 32'h60, 8'd3);
        wait_done(lat);
        chk("t2_latency", lat, 43);
        tick();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t2_mem%0d", i), mem[8'h60 + 8'(i)], 32'(1001 * (i + 1)));
        end
        chk("t2_reads", rd_cnt - rd0, 24);
        chk("t2_writes", wr_cnt - wr0, 12);

        // ---- overflow sticks across a clean vector ----
        preload(8'h70, 32'd0);
        preload(8'h71, 32'd0);
        preload(8'h72, 32'h7FFFFFFF);
        preload(8'h73, 32'd0);
        preload(8'h74, 32'd5);
        preload(8'h75, 32'd1);
        preload(8'h76, 32'd2);
        preload(8'h77, 32'd3);
        preload(8'h78, 32'd0);
        preload(8'h79, 32'd0);
        preload(8'h7A, 32'd1);
        preload(8'h7B, 32'd0);
        preload(8'h7C, 32'hFFFFFFFB);
        preload(8'h7D, 32'd1);
        preload(8'h7E, 32'd1);
        preload(8'h7F, 32'd1);
        issue(CMD_ADD, 32'h70, 32'h78, 32'h80, 8'd2);
        wait_done(lat);
        chk("t3_latency", lat, 29);
        chk("t3_ovf", ovf_sticky, 1);
        chk("t3_zmask", zero_mask, 4'b0001);
        tick();
        chk("t3_mem_ovf_lane", mem[8'h82], 32'h80000000);
        chk("t3_mem_v1l0", mem[8'h84], 0);
        chk("t3_mem_v1l3", mem[8'h87], 4);
        chk("t3_ovf_hold", ovf_sticky, 1);

        // ---- count zero: ovf clears on acceptance, no strobes ----
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        issue(CMD_ADD, 32'h10, 32'h20, 32'hF0, 8'd0);
        chk("t4_ovf_clear", ovf_sticky, 0);
        wait_done(lat);
        chk("t4_latency", lat, 1);
        tick();
        chk("t4_idle", req_ready, 1);
        chk("t4_zmask_hold", zero_mask, 4'b0001);
        chk("t4_reads", rd_cnt - rd0, 0);
        chk("t4_writes", wr_cnt - wr0, 0);

        // ---- request held valid while busy ----
        for (int i = 0; i < 4; i++) begin
            preload(8'h90 + 8'(i), 32'(i + 7));
            preload(8'h98 + 8'(i), 32'd1);
        end
        @(negedge clk);
        req_cmd    = CMD_ADD;
        req_a_base = 32'h10;
        req_b_base = 32'h20;
        req_d_base = 32'hA0;
        req_count  = 8'd1;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_cmd    = CMD_SUB;
        req_a_base = 32'h90;
        req_b_base = 32'h98;
        req_d_base = 32'hB0;
        req_count  = 8'd1;
        tick();
        chk("t5_ignored_ready", req_ready, 0);
        chk("t5_cmd_first", core_command, CMD_ADD);
        wait_done(lat);
        chk("t5_latency1", lat + 1, 15);
        chk("t5_memA0", mem[8'hA0], 11);
        chk("t5_memA3", mem[8'hA3], 44);
        tick();
        chk("t5_idle_gap", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("t5_cmd_second", core_command, CMD_SUB);
        wait_done(lat);
        chk("t5_latency2", lat, 15);
        tick();
        chk("t5_memB0", mem[8'hB0], 6);
        chk("t5_memB3", mem[8'hB3], 9);
        chk("t5_memA1_kept", mem[8'hA1], 22);

        // ---- reset during STORE lane 1 ----
        preload(8'hC1, 32'hDEAD);
        wr0 = wr_cnt;
        issue(CMD_SUB, 32'h10, 32'h10, 32'hC0, 8'd1);
        n = 0;
        while (!(mem_wr_en && mem_addr == 32'hC1) && n < 100) begin
            tick();
            n++;
        end
        chk("t6_reached_store1", n < 100, 1);
        chk("t6_zmask_before", zero_mask, 4'b1111);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_wr_en", mem_wr_en, 0);
        chk("t6_async_addr", mem_addr, 0);
        chk("t6_async_ready", req_ready, 1);
        chk("t6_async_cmd", core_command, 0);
        chk("t6_async_zmask", zero_mask, 0);
        chk("t6_async_opA", core_opA_s, 0);
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b0;
        repeat (20) tick();
        chk("t6_writes", wr_cnt - wr0, 1);
        chk("t6_lane0_written", mem[8'hC0], 0);
        chk("t6_lane1_untouched", mem[8'hC1], 32'hDEAD);
        chk("t6_ready_after", req_ready, 1);
        chk("t6_done_low", done, 0);
        chk("no_rd_wr_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simd_vec_sequencer.md
Name: simd_vec_sequencer

Overview:
- Sequences the SIMD ALU core over operand vectors held in a word-addressed memory.
- Per accepted request it loops `req_count` times: gather ALUWIDTH lanes of A and B, present them to the core, capture the result and flags, then scatter the result lanes back to memory.
- Sits between the instruction/issue logic (valid/ready request) and the core plus a single-port data memory.

Parameters:
- ALUWIDTH, 4, lanes per vector (≥1).
- ADDRW, 32, memory word-address width.
- CNTW, 8, width of the vector-count field.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  sequencer can accept (high only in IDLE).
- req_cmd  in  3  ALU command for all vectors of the request.
- req_a_base  in  ADDRW  word address of A vector 0, lane 0.
- req_b_base  in  ADDRW  word address of B vector 0, lane 0.
- req_d_base  in  ADDRW  word address of destination vector 0.
- req_count  in  CNTW  number of vectors.
- done  out  1  one-cycle pulse when the request completes.
- ovf_sticky  out  1  OR of every lane overflow this request.
- zero_mask  out  ALUWIDTH  iszero flags of the last vector executed.
- mem_addr  out  ADDRW  memory address.
- mem_rd_en  out  1  read strobe; data returned next cycle.
- mem_rdata  in  32  read data.
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  32  write data.
- core_command  out  3  to core command.
- core_opA_s  out  32*ALUWIDTH  flat A lanes; lane i at [32*i +: 32].
- core_opB_s  out  32*ALUWIDTH  flat B lanes.
- core_result_s  in  32*ALUWIDTH  core results, combinational.
- core_iszero_s  in  ALUWIDTH  per-lane zero flags.
- core_overflow_s  in  ALUWIDTH  per-lane overflow flags.

Behaviour:
- Reset (async): state IDLE.
  - Outputs: req_ready=1, done=0, ovf_sticky=0, zero_mask=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, core_command=0.
  - Lane buffers cleared.
- Reset mid-operation aborts immediately; no further memory writes are issued.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready: latch cmd, bases and count; clear ovf_sticky; set vector index v=0.
  - If count==0, go to DONE; otherwise go to LOAD.
- LOAD, 2*ALUWIDTH cycles, mem_rd_en=1 every cycle:
  - Cycle k<ALUWIDTH: mem_addr = a_base + v*ALUWIDTH + k.
  - Cycle k≥ALUWIDTH: mem_addr = b_base + v*ALUWIDTH + (k-ALUWIDTH).
  - mem_rdata is captured one cycle after each read into the matching lane buffer.
- DRAIN, 1 cycle: captures the final B lane; no memory strobe.
- EXEC, 1 cycle:
  - Core inputs are driven from the lane buffers.
  - At the end of the cycle, register core_result_s into the result buffer and core_iszero_s into zero_mask.
  - ovf_sticky |= |core_overflow_s.
- STORE, ALUWIDTH cycles, mem_wr_en=1:
  - Cycle j: mem_addr = d_base + v*ALUWIDTH + j, mem_wdata = result lane j.
  - Then v=v+1. If v==count, go to DONE; otherwise go to LOAD.
- DONE, 1 cycle: done=1, then IDLE. ovf_sticky and zero_mask hold until the next request is accepted.
- Per-vector latency: 3*ALUWIDTH+2 cycles. Request latency from acceptance to done: count*(3*ALUWIDTH+2)+1.
- core_command equals the latched cmd from acceptance until the next acceptance. core_opA_s/opB_s always reflect the lane buffers.
- Address arithmetic wraps modulo 2^ADDRW. The v*ALUWIDTH product is computed at ADDRW width.
- mem_rd_en and mem_wr_en are never high together. mem_addr holds its last value when no strobe is active.
- req_valid while busy is ignored (req_ready=0). Input fields are sampled only at acceptance.

Optional Feature:
- Macro SIMD_SEQ_PERF_EN.
- When defined, add two outputs:
  - perf_cycles, 32 bits: cycles spent outside IDLE since reset.
  - perf_vectors, 32 bits: vectors completed since reset.
- Both counters wrap and are cleared by reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - The 3-bit ALU command encodings, already shared with the core.
  - The state encodings (IDLE, LOAD, DRAIN, EXEC, STORE, DONE).
  - The per-vector cycle-cost constant.
- One natural sub-module, simd_lane_buffer:
  - ALUWIDTH×32 register file with indexed write and a flat 32*ALUWIDTH read.
  - Instantiated three times: A, B, result.

Test Plan:
- ADD, count=1, A=[1,2,3,4], B=[10,20,30,40], ALUWIDTH=4:
  - Memory at d_base reads [11,22,33,44].
  - done pulses 15 cycles after acceptance.
  - ovf_sticky=0, zero_mask=0000.
- ADD, count=3, consecutive vectors:
  - 12 destination words are correct.
  - Exactly 24 reads and 12 writes.
  - done at 43 cycles.
- Lane 2 A=0x7FFFFFFF, B=1 with ADD:
  - ovf_sticky=1 and it stays 1 after a later non-overflowing vector in the same request.
  - ovf_sticky clears on the next acceptance.
- count=0:
  - done one cycle after acceptance.
  - No mem_rd_en or mem_wr_en ever asserted.
- reset asserted during STORE lane 1:
  - Outputs go to reset values asynchronously.
  - No further writes occur.
  - req_ready=1 after reset deasserts.
- req_valid held high during a busy request with different fields:
  - Ignored; the second request is accepted only in IDLE after done.
  - The first request's results are unaffected.
